// File: rtl/dds_pkg.sv
// dds_pkg: widths and encodings shared by the dds generator and the tone meter.
package dds_pkg;

  function automatic int sample_w(input int n);
    return 2 * n + 1;
  endfunction

  localparam logic [0:0] WAIT_EDGE = 1'b0;
  localparam logic [0:0] MEASURE   = 1'b1;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage

// File: rtl/dds_meter_div.sv
// dds_meter_div: restoring divider producing floor(2^FREQ_SHIFT / divisor) in CNT_W+1 clocks.
// A start while busy restarts the division; the quotient saturates to all-ones.
module dds_meter_div #(
  parameter int CNT_W      = 24,
  parameter int FREQ_SHIFT = 16,
  parameter int Q_W        = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] divisor,
  output logic [Q_W-1:0]   quot,
  output logic             quot_valid
);

  localparam int DW = CNT_W + 1;
  localparam int IW = $clog2(DW + 1);
  localparam logic [DW-1:0] DIVIDEND = DW'(1) << FREQ_SHIFT;
  localparam logic [IW-1:0] ITER_ONE  = IW'(1);
  localparam logic [IW-1:0] ITER_LAST = IW'(DW - 1);

  logic             busy;
  logic [IW-1:0]    iter;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [DW-1:0]    quo, quo_nxt;
  logic [CNT_W-1:0] dvs;

  // One restoring step: shift the next dividend bit into the remainder.
  function automatic logic [CNT_W+DW-1:0] div_step(input logic [CNT_W-1:0] r,
                                                    input logic [DW-1:0]    q,
                                                    input logic [CNT_W-1:0] d);
    logic [DW-1:0] r_sh;
    r_sh = {r, q[DW-1]};
    if (r_sh >= {1'b0, d})
      return {r_sh[CNT_W-1:0] - d, q[DW-2:0], 1'b1};
    else
      return {r_sh[CNT_W-1:0], q[DW-2:0], 1'b0};
  endfunction

  function automatic logic [Q_W-1:0] sat_q(input logic [DW-1:0] q, input logic [CNT_W-1:0] d);
    if (d == '0 || (q >> Q_W) != '0)
      return '1;
    else
      return Q_W'(q);
  endfunction

  always_comb begin
    if (start)
      {rem_nxt, quo_nxt} = div_step('0, DIVIDEND, divisor);
    else
      {rem_nxt, quo_nxt} = div_step(rem, quo, dvs);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= 1'b0;
      iter       <= '0;
      quot       <= '0;
      quot_valid <= 1'b0;
    end else begin
      quot_valid <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        iter <= ITER_ONE;
      end else if (busy) begin
        iter <= iter + ITER_ONE;
        if (iter == ITER_LAST) begin
          busy       <= 1'b0;
          quot_valid <= 1'b1;
          quot       <= sat_q(quo_nxt, dvs);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start || busy) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
    if (start)
      dvs <= divisor;
  end

endmodule

// File: rtl/dds_tone_meter.sv
// dds_tone_meter: measures average period, peak and trough of a dds sample stream.
// Define DDS_METER_FREQ_EN to add freq_out/freq_valid from a sequential divider.
module dds_tone_meter
  import dds_pkg::*;
#(
  parameter int N          = 8,
  parameter int CNT_W      = 24,
  parameter int HYST       = 4,
  parameter int AVG_LOG2   = 2,
  parameter int FREQ_SHIFT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic signed [2*N:0] sample_in,
  input  logic                sample_valid,
  output logic [CNT_W-1:0]    period_out,
  output logic signed [2*N:0] peak_out,
  output logic signed [2*N:0] trough_out,
  output logic                meas_valid,
`ifdef DDS_METER_FREQ_EN
  output logic [N:0]          freq_out,
  output logic                freq_valid,
`endif
  output logic                no_signal
);

  localparam int SW = sample_w(N);
  localparam int EW = AVG_LOG2 + 1;
  localparam logic signed [SW-1:0] HYST_POS = SW'(HYST);
  localparam logic signed [SW-1:0] HYST_NEG = -HYST_POS;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [EW-1:0]    EDGE_ONE    = EW'(1);
  localparam logic [EW-1:0]    EDGE_LAST   = EW'((1 << AVG_LOG2) - 1);

  if (HYST <= 0 || FREQ_SHIFT > CNT_W) begin : g_bad_param
    $error("dds_tone_meter: HYST must be > 0 and FREQ_SHIFT <= CNT_W");
  end

  logic                 level, level_nxt;
  logic [0:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [EW-1:0]        edges, edges_nxt;
  logic signed [SW-1:0] peak, peak_nxt, trough, trough_nxt;
  logic signed [SW-1:0] peak_win, trough_win;
  logic                 rise_p0, done_p0, sat_p0;

  // Stage 0: Schmitt trigger, window bookkeeping on the current sample
  always_comb begin
    level_nxt = level;
    rise_p0   = 1'b0;
    if (level == HIGH && sample_in <= HYST_NEG) begin
      level_nxt = LOW;
    end else if (level == LOW && sample_in >= HYST_POS) begin
      level_nxt = HIGH;
      rise_p0   = 1'b1;
    end

    peak_win   = (sample_in > peak)   ? sample_in : peak;
    trough_win = (sample_in < trough) ? sample_in : trough;

    state_nxt  = state;
    cnt_nxt    = cnt;
    edges_nxt  = edges;
    peak_nxt   = peak;
    trough_nxt = trough;
    done_p0    = 1'b0;
    sat_p0     = 1'b0;

    case (state)
      WAIT_EDGE: begin
        if (rise_p0) begin
          state_nxt  = MEASURE;
          cnt_nxt    = CNT_ONE;
          edges_nxt  = '0;
          peak_nxt   = sample_in;
          trough_nxt = sample_in;
        end
      end
      default: begin
        // Saturation takes priority over an edge arriving on the same sample.
        if (cnt == CNT_SAT_PRE) begin
          sat_p0    = 1'b1;
          state_nxt = WAIT_EDGE;
          cnt_nxt   = '0;
        end else if (rise_p0 && edges == EDGE_LAST) begin
          done_p0    = 1'b1;
          cnt_nxt    = CNT_ONE;
          edges_nxt  = '0;
          peak_nxt   = sample_in;
          trough_nxt = sample_in;
        end else begin
          cnt_nxt    = cnt + CNT_ONE;
          peak_nxt   = peak_win;
          trough_nxt = trough_win;
          if (rise_p0)
            edges_nxt = edges + EDGE_ONE;
        end
      end
    endcase
  end

  // Stage 1: registered control and measurement outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      level      <= HIGH;
      state      <= WAIT_EDGE;
      cnt        <= '0;
      edges      <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
      period_out <= '0;
      peak_out   <= '0;
      trough_out <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (sample_valid) begin
        level <= level_nxt;
        state <= state_nxt;
        cnt   <= cnt_nxt;
        edges <= edges_nxt;
        if (done_p0) begin
          meas_valid <= 1'b1;
          no_signal  <= 1'b0;
          period_out <= cnt >> AVG_LOG2;
          peak_out   <= peak_win;
          trough_out <= trough_win;
        end
        if (sat_p0) begin
          no_signal  <= 1'b1;
          period_out <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sample_valid) begin
      peak   <= peak_nxt;
      trough <= trough_nxt;
    end
  end

`ifdef DDS_METER_FREQ_EN
  dds_meter_div #(
    .CNT_W      (CNT_W),
    .FREQ_SHIFT (FREQ_SHIFT),
    .Q_W        (N + 1)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .start      (meas_valid),
    .divisor    (period_out),
    .quot       (freq_out),
    .quot_valid (freq_valid)
  );
`endif

endmodule

// File: tb/tb_dds_tone_meter.sv
// tb_dds_tone_meter: directed and randomized square-wave stimulus against a
// window-queue reference model of the tone meter.
module tb_dds_tone_meter;

  localparam int N          = 8;
  localparam int CNT_W      = 8;
  localparam int HYST       = 4;
  localparam int AVG_LOG2   = 2;
  localparam int FREQ_SHIFT = 8;
  localparam int SW         = 2 * N + 1;
  localparam int NAVG       = 1 << AVG_LOG2;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic [CNT_W-1:0]     period_out;
  logic signed [SW-1:0] peak_out, trough_out;
  logic                 meas_valid, no_signal;
`ifdef DDS_METER_FREQ_EN
  logic [N:0]           freq_out;
  logic                 freq_valid;
`endif

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  dds_tone_meter #(
    .N(N), .CNT_W(CNT_W), .HYST(HYST), .AVG_LOG2(AVG_LOG2), .FREQ_SHIFT(FREQ_SHIFT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (period_out),
    .peak_out     (peak_out),
    .trough_out   (trough_out),
    .meas_valid   (meas_valid),
`ifdef DDS_METER_FREQ_EN
    .freq_out     (freq_out),
    .freq_valid   (freq_valid),
`endif
    .no_signal    (no_signal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model: the open window is a queue of the samples seen since its start edge.
  bit     m_high;
  bit     m_armed;
  int     m_win[$];
  int     m_edges;
  int     e_period, e_peak, e_trough;
  bit     e_nosig, e_mv;
  longint f_due = -1;
  int     f_val;
  longint mv_cyc[$];
  bit     ns_seen;
  longint ns_cyc;

  function automatic void model_reset();
    m_high = 1; m_armed = 0; m_win.delete(); m_edges = 0;
    e_period = 0; e_peak = 0; e_trough = 0; e_nosig = 0; e_mv = 0;
    f_due = -1;
  endfunction

  function automatic void model_sample(input int s);
    bit rise = 0;
    e_mv = 0;
    if (m_high && s <= -HYST) m_high = 0;
    else if (!m_high && s >= HYST) begin m_high = 1; rise = 1; end
    if (!m_armed) begin
      if (rise) begin m_armed = 1; m_win = {s}; m_edges = 0; end
    end else if (m_win.size() + 1 == CMAX) begin
      e_nosig = 1; e_period = 0; m_armed = 0; m_win.delete();
    end else if (rise && m_edges + 1 == NAVG) begin
      e_period = m_win.size() / NAVG;
      e_peak = s; e_trough = s;
      foreach (m_win[i]) begin
        if (m_win[i] > e_peak)   e_peak   = m_win[i];
        if (m_win[i] < e_trough) e_trough = m_win[i];
      end
      e_mv = 1; e_nosig = 0; m_win = {s}; m_edges = 0;
    end else begin
      if (rise) m_edges++;
      m_win.push_back(s);
    end
  endfunction

  task automatic step(input bit v, input int s, input bit r = 1'b0);
    int junk;
    junk = int'($urandom_range(0, 2000)) - 1000;
    reset        = r;
    sample_valid = v;
    sample_in    = v ? SW'(s) : SW'(junk);
    if (r) model_reset();
    else if (v) model_sample(s);
    else e_mv = 0;
    @(posedge clock);
    #1;
    cyc++;
    check("meas_valid", meas_valid, e_mv);
    check("period_out", period_out, e_period);
    check("peak_out",   peak_out,   e_peak);
    check("trough_out", trough_out, e_trough);
    check("no_signal",  no_signal,  e_nosig);
    if (meas_valid) mv_cyc.push_back(cyc);
    if (no_signal && !ns_seen) begin ns_seen = 1; ns_cyc = cyc; end
`ifdef DDS_METER_FREQ_EN
    check("freq_valid", freq_valid, cyc == f_due);
    if (r) check("freq_out_rst", freq_out, 0);
    if (cyc == f_due) check("freq_out", freq_out, f_val);
    if (e_mv) begin
      f_due = cyc + CNT_W + 1;
      if (e_period == 0) f_val = (1 << (N + 1)) - 1;
      else begin
        f_val = (1 << FREQ_SHIFT) / e_period;
        if (f_val > (1 << (N + 1)) - 1) f_val = (1 << (N + 1)) - 1;
      end
    end
`endif
  endtask

  // gap: 0 = always valid, 1 = alternate valid/idle, 2 = random idle bursts
  task automatic square(input int half, input int amp, input int nper, input int gap,
                        input int jitter = 0);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < 2 * half; i++) begin
        int s;
        s = (i < half) ? amp : -amp;
        if (jitter > 0) s += int'($urandom_range(0, 2 * jitter)) - jitter;
        if (gap == 2) while ($urandom_range(0, 3) == 0) step(0, 0);
        step(1, s);
        if (gap == 1) step(0, 0);
      end
    end
  endtask

  task automatic begin_scenario(output longint c0);
    step(0, 0, 1);
    mv_cyc.delete();
    ns_seen = 0;
    c0 = cyc;
  endtask

  initial begin
    longint c0;
    model_reset();
    ns_seen = 0;

    step(0, 0, 1);
    step(1, 100, 1);
    check("rst_period", period_out, 0);
    check("rst_meas_valid", meas_valid, 0);

    // Square wave, continuous samples
    begin_scenario(c0);
    square(8, 100, 10, 0);
    check("sq_pulses", mv_cyc.size(), 2);
    if (mv_cyc.size() >= 2) begin
      check("sq_first_pulse", mv_cyc[0] - c0, 81);
      check("sq_spacing", mv_cyc[1] - mv_cyc[0], 64);
    end
    check("sq_period", period_out, 16);
    check("sq_peak", peak_out, 100);
    check("sq_trough", trough_out, -100);

    // Same wave with sample_valid toggling every clock
    begin_scenario(c0);
    square(8, 100, 10, 1);
    check("gap_pulses", mv_cyc.size(), 2);
    if (mv_cyc.size() >= 2) check("gap_spacing", mv_cyc[1] - mv_cyc[0], 128);
    check("gap_period", period_out, 16);

    // Samples inside the hysteresis band never make an edge
    begin_scenario(c0);
    for (int i = 0; i < 300; i++) step(1, (i % 2) ? 3 : -3);
    for (int i = 0; i < 100; i++) step(1, int'($urandom_range(0, 6)) - 3);
    check("hyst_pulses", mv_cyc.size(), 0);
    check("hyst_no_signal", no_signal, 0);

    // One full window, then a stuck-high input saturates the counter
    begin_scenario(c0);
    square(8, 100, 6, 0);
    for (int i = 0; i < 300; i++) step(1, 50);
    check("sat_seen", ns_seen, 1);
    if (ns_seen) check("sat_cycle", ns_cyc - c0, 335);
    check("sat_period", period_out, 0);
    mv_cyc.delete();
    square(8, 100, 6, 0);
    check("sat_recover_pulses", mv_cyc.size(), 1);
    check("sat_recover_nosig", no_signal, 0);
    check("sat_recover_period", period_out, 16);

    // Reset in the middle of a window
    for (int i = 0; i < 30; i++) step(1, ((i % 16) < 8) ? 100 : -100);
    step(0, 0, 1);
    check("midrst_period", period_out, 0);
    check("midrst_peak", peak_out, 0);
    check("midrst_nosig", no_signal, 0);
    mv_cyc.delete();
    c0 = cyc;
    square(8, 100, 6, 0);
    check("midrst_pulses", mv_cyc.size(), 1);
    if (mv_cyc.size() >= 1) check("midrst_first_pulse", mv_cyc[0] - c0, 81);

    // Randomized tones, gaps, jitter and occasional saturation
    for (int seg = 0; seg < 30; seg++) begin
      int half, amp, nper, gap;
      half = int'($urandom_range(2, 40));
      amp  = int'($urandom_range(HYST + 12, 3000));
      nper = int'($urandom_range(1, 8));
      gap  = ($urandom_range(0, 2) == 0) ? 2 : 0;
      square(half, amp, nper, gap, 10);
      if ($urandom_range(0, 4) == 0)
        for (int i = 0; i < 20; i++) step(1, int'($urandom_range(0, 600)) - 300);
      if ($urandom_range(0, 9) == 0) step(0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
